haar_frame_reader: RTL

Avalon-MM burst read master that fetches a contiguous image region from HPS SDRAM through the FPGA-to-SDRAM bridge. It delivers the words as a valid/ready stream to the Haar integral-image and classifier pipeline. It is the consumer side of the memory path that haar_system exports. Flow control is credit-based, so the internal FIFO never overflows, whatever the read latency.

---
 rtl/haar_reader_pkg.sv | 23 ++
 rtl/haar_sync_fifo.sv | 49 ++++
 rtl/haar_frame_reader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/haar_reader_pkg.sv
// Shared types and sizing helpers for the Haar frame reader and its FIFO.
package haar_reader_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  function automatic int bytes_per_word(int data_w);
    return data_w / 8;
  endfunction

  // Burstcount needs one extra bit so that BURST_LEN itself is encodable.
  function automatic int bc_width(int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

  function automatic int cnt_width(int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned min_burst(int unsigned remaining, int unsigned burst_len);
    return (remaining < burst_len) ? remaining : burst_len;
  endfunction

endpackage

// File: rtl/haar_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered occupancy count.
module haar_sync_fifo #(
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign do_rd   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write at full is still taken.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(do_wr) - (PTR_W+1)'(do_rd);
    end
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(wr_en && full && !do_rd)) else $error("haar_sync_fifo overflow");
  end

endmodule

// File: rtl/haar_frame_reader.sv
// Avalon-MM burst read master feeding a valid/ready stream; credit-based so the
// read-data FIFO can never overflow regardless of slave latency.
module haar_frame_reader
  import haar_reader_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 24
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [LEN_W-1:0]           len_words,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_W-1:0]          avm_address,
  output logic                       avm_read,
  output logic [$clog2(BURST_LEN):0] avm_burstcount,
  input  logic                       avm_waitrequest,
  input  logic [DATA_W-1:0]          avm_readdata,
  input  logic                       avm_readdatavalid,
  output logic [DATA_W-1:0]          st_data,
  output logic                       st_valid,
  input  logic                       st_ready,
  output logic                       st_last
);
  localparam int BYTES_PER_WORD = bytes_per_word(DATA_W);
  localparam int BC_W           = bc_width(BURST_LEN);
  localparam int CNT_W          = cnt_width(FIFO_DEPTH);
  localparam int CR_W           = CNT_W + 2;
  localparam int WB_SH          = $clog2(BYTES_PER_WORD);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [LEN_W-1:0]  req_rem, rem_nxt, len_q, dlv_cnt;
  logic [CNT_W-1:0]  outstanding, fifo_count;
  logic [BC_W-1:0]   burst_nxt;
  logic [CR_W-1:0]   reserved;
  logic              accept, launch, rdv_ok, st_hs, zero_done, issue_en;
  logic              fifo_empty, fifo_full;

  // addr_q / req_rem always describe the next burst not yet accepted by the slave.
  assign accept    = avm_read && !avm_waitrequest;
  assign rem_nxt   = accept ? req_rem - LEN_W'(avm_burstcount) : req_rem;
  assign addr_nxt  = accept ? addr_q + (ADDR_W'(avm_burstcount) << WB_SH) : addr_q;
  assign burst_nxt = BC_W'(min_burst(32'(rem_nxt), BURST_LEN));
  // Pops this cycle are ignored, which only makes the credit check conservative.
  assign reserved  = CR_W'(fifo_count) + CR_W'(outstanding)
                   + (accept ? CR_W'(avm_burstcount) : CR_W'(0));
  assign launch    = issue_en && (rem_nxt != '0)
                   && (reserved + CR_W'(burst_nxt) <= CR_W'(FIFO_DEPTH));
  assign rdv_ok    = avm_readdatavalid && (state != IDLE);
  assign st_valid  = !fifo_empty;
  assign st_hs     = st_valid && st_ready;
  assign st_last   = st_valid && (dlv_cnt == len_q - LEN_W'(1));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && len_words != '0) state_nxt = ISSUE;
      ISSUE:   if (accept && rem_nxt == '0)  state_nxt = DRAIN;
      DRAIN:   if (st_hs && st_last)         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    issue_en = (state == ISSUE);
    done     = zero_done || ((state == DRAIN) && st_hs && st_last);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      addr_q         <= '0;
      req_rem        <= '0;
      len_q          <= '0;
      dlv_cnt        <= '0;
      outstanding    <= '0;
      zero_done      <= 1'b0;
      avm_read       <= 1'b0;
      avm_address    <= '0;
      avm_burstcount <= '0;
    end else begin
      zero_done <= (state == IDLE) && start && (len_words == '0);
      if (state == IDLE && start && len_words != '0) begin
        addr_q  <= base_addr & ~ADDR_W'(BYTES_PER_WORD - 1);
        req_rem <= len_words;
        len_q   <= len_words;
        dlv_cnt <= '0;
      end else begin
        addr_q  <= addr_nxt;
        req_rem <= rem_nxt;
        if (st_hs) dlv_cnt <= dlv_cnt + LEN_W'(1);
      end
      outstanding <= outstanding + (accept ? CNT_W'(avm_burstcount) : CNT_W'(0))
                   - CNT_W'(rdv_ok);
      // Request fields only move once the current request has been taken.
      if (!avm_read || accept) begin
        avm_read <= launch;
        if (launch) begin
          avm_address    <= addr_nxt;
          avm_burstcount <= burst_nxt;
        end
      end
    end
  end

  haar_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .wr_en   (rdv_ok),
    .wr_data (avm_readdata),
    .rd_en   (st_hs),
    .rd_data (st_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  always @(posedge clk_clk) begin
    if (reset_reset_n) begin
      assert (!(avm_readdatavalid && state == IDLE)) else $error("readdatavalid while idle, word dropped");
      assert (!(rdv_ok && fifo_full && !st_hs)) else $error("read data arrived without credit");
    end
  end

endmodule
